// File: rtl/matrix_vector_transform_if.sv
// matrix_vector_transform_if: word memory read/write port of the transform engine
interface matrix_vector_transform_if #(
  parameter int WIDTH = 32
) ();
  logic             rd_req;
  logic [WIDTH-1:0] rd_addr;
  logic             rd_gnt;
  logic             rd_rvalid;
  logic [WIDTH-1:0] rd_rdata;
  logic             wr_req;
  logic [WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_gnt;
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_gnt, rd_rvalid, rd_rdata, wr_gnt
  );
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_gnt, rd_rvalid, rd_rdata, wr_gnt
  );
endinterface

// File: rtl/matrix_vector_transform.sv
// matrix_vector_transform: fixed-point DIMxDIM matrix times vector stream engine with matrix reuse
module matrix_vector_transform #(
  parameter int WIDTH   = 32,
  parameter int DIM     = 4,
  parameter int FRAC    = 16,
  parameter int COUNT_W = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 reuse_matrix,
  input  logic [COUNT_W-1:0]   item_count,
  input  logic [WIDTH-1:0]     mat_addr,
  input  logic [WIDTH-1:0]     vec_addr,
  input  logic [WIDTH-1:0]     out_addr,
  matrix_vector_transform_if.master mem,
  output logic                 busy,
  output logic                 done,
  output logic                 mat_valid,
  output logic [COUNT_W-1:0]   items_left
);
  localparam int BYTES = WIDTH / 8;
  localparam int IDX_W = $clog2(DIM * DIM + 1);
  localparam int MI_W  = $clog2(DIM * DIM);
  localparam int DIM_W = $clog2(DIM);
  localparam logic [DIM_W-1:0] LAST = DIM_W'(DIM - 1);
  typedef enum logic [2:0] {IDLE, LD_MAT, LD_VEC, MAC, WR, DONE} state_t;
  state_t state, nextState;
  logic [WIDTH-1:0] matCache [DIM*DIM];
  logic [WIDTH-1:0] vecCache [DIM];
  logic [WIDTH-1:0] matBase, vecPtr, outPtr, acc, term;
  logic [IDX_W-1:0] idx;
  logic [MI_W-1:0]  mIdx;
  logic [DIM_W-1:0] row, col;
  logic             pending, rdFire, rdBeat, wrFire, lastWord;
  logic signed [2*WIDTH-1:0] prod, shifted;
  // Memory handshakes and the single-product multiply for the current row/column
  always_comb begin
    mem.rd_req  = (state == LD_MAT || state == LD_VEC) && !pending;
    mem.rd_addr = !mem.rd_req ? '0 : state == LD_MAT ? matBase + WIDTH'(idx) * WIDTH'(BYTES) : vecPtr;
    mem.wr_req  = state == WR;
    mem.wr_addr = mem.wr_req ? outPtr : '0;
    mem.wr_data = mem.wr_req ? acc : '0;
    rdFire      = mem.rd_req && mem.rd_gnt;
    rdBeat      = pending && mem.rd_rvalid;
    wrFire      = mem.wr_req && mem.wr_gnt;
    lastWord    = idx == (state == LD_MAT ? IDX_W'(DIM * DIM - 1) : IDX_W'(DIM - 1));
    mIdx        = MI_W'(row * DIM + col);
    prod        = (2*WIDTH)'($signed(matCache[mIdx])) * (2*WIDTH)'($signed(vecCache[col]));
    shifted     = prod >>> FRAC;
    term        = shifted[WIDTH-1:0];
    busy        = state != IDLE;
    done        = state == DONE;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  // Next-state selection
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start) nextState = item_count == '0 ? DONE : (reuse_matrix && mat_valid) ? LD_VEC : LD_MAT;
      LD_MAT:  if (rdBeat && lastWord) nextState = LD_VEC;
      LD_VEC:  if (rdBeat && lastWord) nextState = MAC;
      MAC:     if (col == LAST) nextState = WR;
      WR:      if (wrFire) nextState = row != LAST ? MAC : items_left == COUNT_W'(1) ? DONE : LD_VEC;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  // Pointers, counters, accumulator and matrix-valid flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      matBase    <= '0;
      vecPtr     <= '0;
      outPtr     <= '0;
      acc        <= '0;
      idx        <= '0;
      row        <= '0;
      col        <= '0;
      pending    <= 1'b0;
      mat_valid  <= 1'b0;
      items_left <= '0;
    end else begin
      if (state == IDLE && start) begin
        matBase    <= mat_addr;
        vecPtr     <= vec_addr;
        outPtr     <= out_addr;
        items_left <= item_count;
        acc        <= '0;
        idx        <= '0;
        row        <= '0;
        col        <= '0;
        if (item_count != '0 && !(reuse_matrix && mat_valid)) mat_valid <= 1'b0;
      end
      if (rdFire) pending <= 1'b1;
      else if (rdBeat) pending <= 1'b0;
      if (rdBeat) idx <= lastWord ? '0 : idx + IDX_W'(1);
      if (rdBeat && lastWord && state == LD_MAT) mat_valid <= 1'b1;
      if (rdBeat && state == LD_VEC) vecPtr <= vecPtr + WIDTH'(BYTES);
      if (state == MAC) begin
        acc <= acc + term;
        col <= col == LAST ? '0 : col + DIM_W'(1);
      end
      if (wrFire) begin
        outPtr <= outPtr + WIDTH'(BYTES);
        acc    <= '0;
        row    <= row == LAST ? '0 : row + DIM_W'(1);
        if (row == LAST) items_left <= items_left - COUNT_W'(1);
      end
    end
  // Operand caches filled from read data
  always_ff @(posedge clk) begin
    if (rdBeat && state == LD_MAT) matCache[MI_W'(idx)] <= mem.rd_rdata;
    if (rdBeat && state == LD_VEC) vecCache[DIM_W'(idx)] <= mem.rd_rdata;
  end
endmodule
